// File: rtl/sram_arbiter_pkg.sv
// Shared encodings and widths for the two-master SRAM arbiter.
package sram_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Fetch requests are always reads with no byte lanes enabled.
    localparam logic [STRB_W-1:0] INST_WSTRB = '0;

    // IDLE: free to grant; REQ: driving sram_req; RESP: awaiting sram_data_ok.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Owner of the single outstanding transaction (also used for last grant).
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-input round-robin selector: a lone requester wins, a tie goes to the
// side that was not granted last.
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic   req_inst,
    input  logic   req_data,
    input  owner_e last_grant,
    output logic   grant_valid,
    output owner_e grant_owner
);

    // Pick the winner for this cycle from the request pair and the history.
    always_comb begin
        grant_valid = req_inst | req_data;
        grant_owner = OWN_INST;
        if (req_inst && req_data) begin
            grant_owner = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (req_data) begin
            grant_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like port between a fetch master and a load/store master,
// allowing a single outstanding transaction at a time.
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_req,
    output logic              sram_wr,
    output logic [STRB_W-1:0] sram_wstrb,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_addr_ok,
    input  logic              sram_data_ok,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic              wr_q, wr_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic   grant_valid;
    owner_e grant_owner;

    rr_arb2 u_rr_arb2 (
        .req_inst    (inst_req),
        .req_data    (data_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // State and latched transaction fields; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            last_grant_q <= OWN_INST;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state and handshake outputs; outputs are forced low while in reset
    // so a completion arriving during reset is never forwarded.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        sram_req     = 1'b0;
        sram_wr      = 1'b0;
        sram_wstrb   = '0;
        sram_addr    = '0;
        sram_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    if (grant_owner == OWN_DATA) begin
                        data_addr_ok = 1'b1;
                        wr_d         = data_wr;
                        wstrb_d      = data_wstrb;
                        addr_d       = data_addr;
                        wdata_d      = data_wdata;
                    end else begin
                        inst_addr_ok = 1'b1;
                        wr_d         = 1'b0;
                        wstrb_d      = INST_WSTRB;
                        addr_d       = inst_addr;
                        wdata_d      = '0;
                    end
                    owner_d      = grant_owner;
                    last_grant_d = grant_owner;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                sram_req   = 1'b1;
                sram_wr    = wr_q;
                sram_wstrb = wstrb_q;
                sram_addr  = addr_q;
                sram_wdata = wdata_q;
                if (sram_addr_ok) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (sram_data_ok) begin
                    if (owner_q == OWN_DATA) begin
                        data_data_ok = 1'b1;
                        data_rdata   = sram_rdata;
                    end else begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = sram_rdata;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!resetn) begin
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = '0;
            sram_req     = 1'b0;
            sram_wr      = 1'b0;
            sram_wstrb   = '0;
            sram_addr    = '0;
            sram_wdata   = '0;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_req, sram_wr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;

    sram_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_req     (sram_req),
        .sram_wr      (sram_wr),
        .sram_wstrb   (sram_wstrb),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_addr_ok (sram_addr_ok),
        .sram_data_ok (sram_data_ok),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Reference model: one outstanding transaction (1 = data side, 0 = inst side).
    bit        m_busy, m_issued, m_owner, m_last;
    bit        m_wr;
    bit [3:0]  m_wstrb;
    bit [31:0] m_addr, m_wdata;
    bit        grant_log[$];
    int        grant_cyc[$];
    bit        exp_seq[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Observation counters and SRAM responder controls.
    int          n_ddo, n_ido, n_sreq, req_cnt, addr_wait;
    bit          rand_sram, hold_resp, use_fix;
    logic [31:0] fix_rdata, last_irdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic timeout(input string tag);
        checks++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, then drive the SRAM responder for the next cycle.
    task automatic tick();
        bit any, win, done;
        @(negedge clk);
        any  = inst_req || data_req;
        win  = (inst_req && data_req) ? ~m_last : data_req;
        done = m_busy && m_issued && sram_data_ok;
        if (!resetn) begin
            chk("rst_inst_addr_ok", inst_addr_ok, 0);
            chk("rst_inst_data_ok", inst_data_ok, 0);
            chk("rst_inst_rdata", inst_rdata, 0);
            chk("rst_data_addr_ok", data_addr_ok, 0);
            chk("rst_data_data_ok", data_data_ok, 0);
            chk("rst_data_rdata", data_rdata, 0);
            chk("rst_sram_req", sram_req, 0);
            chk("rst_sram_wr", sram_wr, 0);
            chk("rst_sram_wstrb", sram_wstrb, 0);
            chk("rst_sram_addr", sram_addr, 0);
            chk("rst_sram_wdata", sram_wdata, 0);
        end else begin
            chk("inst_addr_ok", inst_addr_ok, !m_busy && any && !win);
            chk("data_addr_ok", data_addr_ok, !m_busy && any && win);
            chk("sram_req", sram_req, m_busy && !m_issued);
            if (m_busy && !m_issued) begin
                chk("sram_wr", sram_wr, m_wr);
                chk("sram_wstrb", sram_wstrb, m_wstrb);
                chk("sram_addr", sram_addr, m_addr);
                if (m_wr) chk("sram_wdata", sram_wdata, m_wdata);
            end
            chk("inst_data_ok", inst_data_ok, done && !m_owner);
            chk("data_data_ok", data_data_ok, done && m_owner);
            if (done && !m_owner) chk("inst_rdata", inst_rdata, sram_rdata);
            if (done && m_owner && !m_wr) chk("data_rdata", data_rdata, sram_rdata);
        end
        if (data_data_ok) n_ddo++;
        if (inst_data_ok) begin
            n_ido++;
            last_irdata = inst_rdata;
        end
        if (sram_req) n_sreq++;

        @(posedge clk);
        cyc++;
        if (!resetn) begin
            m_busy = 0;
            m_last = 0;
        end else if (!m_busy) begin
            if (any) begin
                m_busy = 1; m_issued = 0; m_owner = win; m_last = win;
                m_wr    = win ? data_wr    : 1'b0;
                m_wstrb = win ? data_wstrb : 4'b0000;
                m_addr  = win ? data_addr  : inst_addr;
                m_wdata = win ? data_wdata : 32'h0;
                grant_log.push_back(win);
                grant_cyc.push_back(cyc);
                req_cnt = 0;
            end
        end else if (!m_issued) begin
            if (sram_addr_ok) m_issued = 1;
        end else if (sram_data_ok) begin
            m_busy = 0;
        end

        #1;
        sram_rdata = use_fix ? fix_rdata : $urandom;
        if (rand_sram) begin
            sram_addr_ok = ($urandom_range(0, 2) == 0);
            sram_data_ok = ($urandom_range(0, 2) == 0);
        end else begin
            sram_addr_ok = m_busy && !m_issued && (req_cnt >= addr_wait);
            if (m_busy && !m_issued) req_cnt++;
            sram_data_ok = m_busy && m_issued && !hold_resp;
        end
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int k = 0;
        while (m_busy && k < lim) begin
            tick();
            k++;
        end
        if (m_busy) timeout(tag);
    endtask

    initial begin
        resetn = 0; inst_req = 1; data_req = 1; data_wr = 0; data_wstrb = 0;
        inst_addr = 32'h1c000040; data_addr = 32'h1c000080; data_wdata = 0;
        sram_addr_ok = 1; sram_data_ok = 1; sram_rdata = 32'h12345678;
        rand_sram = 0; hold_resp = 0; use_fix = 0; addr_wait = 0; fix_rdata = 0;
        repeat (3) tick();

        // Simultaneous requests after reset, then both held for six transactions.
        resetn = 1;
        grant_log.delete(); grant_cyc.delete();
        tick();
        if (grant_log.size() >= 1) chk("first_tie_to_data", grant_log[0], 1);
        else timeout("first_tie_to_data");
        for (int i = 0; i < 60 && grant_log.size() < 6; i++) tick();
        if (grant_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("alt_grant_%0d", i), grant_log[i], exp_seq[i]);
            for (int i = 1; i < 6; i++) chk($sformatf("grant_spacing_%0d", i), grant_cyc[i] - grant_cyc[i-1], 3);
        end else timeout("alternating_grants");
        inst_req = 0; data_req = 0;
        wait_idle(20, "alt_drain");

        // Store with partial strobes, request withdrawn right after acceptance.
        n_ddo = 0; n_ido = 0; grant_log.delete();
        data_req = 1; data_wr = 1; data_addr = 32'h1c000100;
        data_wdata = 32'hdeadbeef; data_wstrb = 4'b0011;
        tick();
        data_req = 0; data_wr = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
        wait_idle(20, "store_done");
        chk("store_granted_data", grant_log.size(), 1);
        chk("store_data_ok_pulses", n_ddo, 1);
        chk("store_inst_data_ok", n_ido, 0);

        // Fetch with three cycles of SRAM back-pressure.
        addr_wait = 3; n_sreq = 0; n_ido = 0; use_fix = 1; fix_rdata = 32'h02c00c0c;
        inst_req = 1; inst_addr = 32'h1c000000;
        tick();
        inst_req = 0; inst_addr = 32'h0badf00d;
        wait_idle(20, "fetch_done");
        chk("fetch_sram_req_cycles", n_sreq, 4);
        chk("fetch_data_ok_pulses", n_ido, 1);
        chk("fetch_rdata", last_irdata, 32'h02c00c0c);
        addr_wait = 0; use_fix = 0;

        // Reset while waiting for the response, completion arriving around it.
        hold_resp = 1; data_req = 1; data_wr = 0; data_addr = 32'h1c000200;
        tick();
        data_req = 0;
        for (int i = 0; i < 10 && !(m_busy && m_issued); i++) tick();
        if (!(m_busy && m_issued)) timeout("reach_resp");
        n_ddo = 0; n_ido = 0;
        resetn = 0; sram_data_ok = 1;
        tick();
        resetn = 1; hold_resp = 0; sram_data_ok = 1;
        tick();
        chk("rst_resp_data_ok", n_ddo, 0);
        chk("rst_resp_inst_ok", n_ido, 0);
        grant_log.delete();
        sram_data_ok = 0; inst_req = 1; data_req = 1;
        tick();
        if (grant_log.size() >= 1) chk("post_reset_tie_to_data", grant_log[0], 1);
        else timeout("post_reset_tie_to_data");
        inst_req = 0; data_req = 0;
        wait_idle(20, "post_reset_drain");

        // Stray completions while idle.
        n_ddo = 0; n_ido = 0;
        sram_data_ok = 1; tick();
        sram_data_ok = 1; tick();
        chk("stray_data_ok", n_ddo, 0);
        chk("stray_inst_ok", n_ido, 0);

        // Randomized traffic, withdrawals, SRAM stalls and occasional resets.
        rand_sram = 1;
        for (int i = 0; i < 500; i++) begin
            resetn     = ($urandom_range(0, 99) != 0);
            inst_req   = ($urandom_range(0, 3) != 0);
            data_req   = ($urandom_range(0, 3) != 0);
            data_wr    = $urandom_range(0, 1);
            data_wstrb = $urandom;
            inst_addr  = $urandom;
            data_addr  = $urandom;
            data_wdata = $urandom;
            tick();
        end
        resetn = 1; inst_req = 0; data_req = 0; rand_sram = 0;
        wait_idle(50, "random_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; it SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  synchronous active-low reset.
REQ-004 inst_req / inst_addr  input  1 / 32  fetch read request and byte address.
REQ-005 inst_addr_ok / inst_data_ok  output  1 / 1  request accepted / read data valid.
REQ-006 inst_rdata  output  32  fetch read data.
REQ-007 data_req / data_wr / data_wstrb  input  1 / 1 / 4  load-store request, write flag, byte strobes.
REQ-008 data_addr / data_wdata  input  32 / 32  load-store address and store data.
REQ-009 data_addr_ok / data_data_ok / data_rdata  output  1 / 1 / 32  accept, completion, load data.
REQ-010 sram_req / sram_wr / sram_wstrb  output  1 / 1 / 4  request to the shared SRAM port.
REQ-011 sram_addr / sram_wdata  output  32 / 32  shared port address and write data.
REQ-012 sram_addr_ok / sram_data_ok / sram_rdata  input  1 / 1 / 32  SRAM accept, completion, read data.

Function
REQ-013 States: IDLE, REQ (sram_req driven, waiting sram_addr_ok), RESP (waiting sram_data_ok); at most one outstanding transaction.
REQ-014 In IDLE with any request pending: grant one requester, pulse its addr_ok for exactly that cycle, latch wr/wstrb/addr/wdata and the grant owner, and enter REQ on the next edge.
REQ-015 Inst requests SHALL latch wr=0 and wstrb=4'b0000.
REQ-016 Arbitration is round-robin on last_grant: on a tie, the requester not granted last wins; a sole requester always wins.
REQ-017 In REQ: sram_req=1 with the latched fields, held stable until sram_addr_ok; on sram_addr_ok, enter RESP and drop sram_req next cycle.
REQ-018 In RESP: on sram_data_ok, pulse the owner's data_ok combinationally in the same cycle; drive the owner's rdata = sram_rdata; return to IDLE.
REQ-019 Writes SHALL also complete via data_data_ok; data_rdata is don't-care for writes.
REQ-020 The non-owner's data_ok SHALL stay 0; sram_data_ok outside RESP SHALL be ignored.
REQ-021 The earliest new grant SHALL occur in the IDLE cycle after completion; minimum transaction latency is 3 cycles (grant, REQ, RESP with zero-wait SRAM).
REQ-022 A request withdrawn before its addr_ok SHALL NOT be issued; once granted, the transaction SHALL complete regardless of the requester's inputs.
REQ-023 addr_ok SHALL never be asserted outside IDLE, and never to both requesters in the same cycle.

Reset
REQ-024 While resetn=0: state=IDLE, last_grant=INST (data wins the first tie), and all outputs 0, including rdata buses.
REQ-025 Reset mid-transaction SHALL abandon it without a data_ok; the SRAM is reset by the same resetn.

Structure
REQ-026 State encoding (IDLE/REQ/RESP) and owner encoding (INST/DATA) SHALL live in a shared package with the other pipeline constants.
REQ-027 The block is a single module; round-robin grant selection MAY be a sub-module rr_arb2 (2-input, last-grant based).

Verification
REQ-028 After reset, inst_req=1 and data_req=1 in the same cycle -> data_addr_ok in cycle 0; data_data_ok in the sram_data_ok cycle; then inst_addr_ok in the next IDLE.
REQ-029 Data store to addr 0x1c000100, wdata 0xdeadbeef, wstrb 4'b0011 -> sram_wr=1, sram_wstrb=4'b0011, and sram_addr/sram_wdata match for every REQ cycle; data_data_ok pulses once; inst_data_ok stays 0.
REQ-030 Inst fetch from 0x1c000000, SRAM holds addr_ok low for 3 cycles and then returns 0x02c00c0c -> sram_req is high for 4 cycles with a stable address; inst_rdata=0x02c00c0c with inst_data_ok.
REQ-031 Both requesters held high for 6 transactions -> grants alternate D,I,D,I,D,I; no requester waits more than one transaction.
REQ-032 resetn asserted while in RESP, then sram_data_ok on the next cycle -> no data_ok on either side; state is IDLE; the next tie goes to data.
REQ-033 Stray sram_data_ok in IDLE with no requests -> both data_ok signals stay 0; state is unchanged.
